// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, types and GF(2^8) helpers for the AES-128
// decryption round engine.
//   AES_BLK_W / AES_WORD_W : block and key-word widths
//   RCON                   : round constants Rcon[0..9]
//   state_e                : round FSM states
//   INV_SR_MAP             : InvShiftRows source index for each output byte
//   gf_mul09/0b/0d/0e      : constant multipliers used by InvMixColumns
package aes_pkg;

    localparam int AES_BLK_W  = 128;
    localparam int AES_WORD_W = 32;

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIN  = 2'd2
    } state_e;

    // Output byte 4c+j (row j) is taken from input byte 4*((c-j) mod 4)+j:
    // row j is rotated right by j columns.
    localparam logic [3:0] INV_SR_MAP [16] = '{
        4'd0,  4'd13, 4'd10, 4'd7,
        4'd4,  4'd1,  4'd14, 4'd11,
        4'd8,  4'd5,  4'd2,  4'd15,
        4'd12, 4'd9,  4'd6,  4'd3
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul09(input logic [7:0] b);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return b8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul0b(input logic [7:0] b);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return b8 ^ b2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul0d(input logic [7:0] b);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return b8 ^ b4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul0e(input logic [7:0] b);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return b8 ^ b4 ^ b2;
    endfunction

    // One column; byte 0 (row 0) lives in bits [7:0].
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
        a0 = col[7:0];
        a1 = col[15:8];
        a2 = col[23:16];
        a3 = col[31:24];
        b0 = gf_mul0e(a0) ^ gf_mul0b(a1) ^ gf_mul0d(a2) ^ gf_mul09(a3);
        b1 = gf_mul09(a0) ^ gf_mul0e(a1) ^ gf_mul0b(a2) ^ gf_mul0d(a3);
        b2 = gf_mul0d(a0) ^ gf_mul09(a1) ^ gf_mul0e(a2) ^ gf_mul0b(a3);
        b3 = gf_mul0b(a0) ^ gf_mul0d(a1) ^ gf_mul09(a2) ^ gf_mul0e(a3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic logic [AES_BLK_W-1:0] inv_mix_columns(input logic [AES_BLK_W-1:0] s);
        logic [AES_BLK_W-1:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[32*c +: 32] = inv_mix_col(s[32*c +: 32]);
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_round_inv_sbox.sv
// inv_sbox: combinational AES inverse S-box (256x8 ROM).
//   in_byte  : lookup address
//   out_byte : InvSubBytes(in_byte)
module inv_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign out_byte = INV_SBOX_TBL[8*(255 - int'(in_byte)) +: 8];

endmodule

// File: rtl/aes_sbox.sv
// sbox: combinational AES forward S-box (256x8 ROM).
//   in_byte  : lookup address
//   out_byte : SubBytes(in_byte)
// Used by the inverse key step to form SubWord(RotWord(w3')).
module sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Entry 0 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign out_byte = SBOX_TBL[8*(255 - int'(in_byte)) +: 8];

endmodule

// File: rtl/aes_inv_round.sv
// aes_inv_round: one AES-128 decryption round plus the inverse key-schedule
// step K(r) -> K(r-1).
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   start      request pulse, sampled only in IDLE
//   i_text     state entering the round (already XORed with K(r))
//   key        round key K(r)
//   round      r, legal range 1..10 (other values are ignored)
//   o_text     InvMixColumns(InvSubBytes(InvShiftRows(i_text)) ^ K(r-1)),
//              InvMixColumns bypassed when r == 1
//   o_key      K(r-1)
//   busy       high whenever the FSM is not in IDLE
//   done       one-cycle pulse; o_text/o_key valid from this cycle on
//   state_dbg  current FSM state (aes_pkg::state_e encoding)
//
// Handshake: a request is accepted on any rising edge where start=1, the FSM
// is in IDLE and round is 1..10; there is no back-pressure and no queueing,
// so start while busy is dropped. done pulses for exactly one cycle and the
// FSM is already IDLE in that cycle, so a new start may be issued alongside it.
// Results hold until the next completed round or reset.
//
// Build option: define AES_INV_PARALLEL_EN to process one column (four
// inverse S-boxes) per cycle, giving done 5 cycles after start instead of
// 17. Results are identical in both builds.
module aes_inv_round
    import aes_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] i_text,
    input  logic [127:0] key,
    input  logic [3:0]   round,
    output logic [127:0] o_text,
    output logic [127:0] o_key,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state_dbg
);

`ifdef AES_INV_PARALLEL_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 4;
`endif
    // SUB always ends when the counter is all ones (15 serial, 3 parallel).
    localparam logic [CNT_W-1:0] LAST_CNT = '1;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [AES_BLK_W-1:0]    text_q, text_d;
    logic [AES_BLK_W-1:0]    key_q, key_d;
    logic [3:0]              round_q, round_d;
    logic [AES_BLK_W-1:0]    stage_q, stage_d;
    logic [AES_WORD_W-1:0]   subw_q, subw_d;
    logic [AES_BLK_W-1:0]    o_text_q, o_text_d;
    logic [AES_BLK_W-1:0]    o_key_q, o_key_d;
    logic                    done_q, done_d;

    logic                    round_legal;
    logic [AES_WORD_W-1:0]   w0, w1, w2, w3;
    logic [AES_WORD_W-1:0]   w0_prev, w1_prev, w2_prev, w3_prev;
    logic [3:0]              rcon_idx;
    logic [AES_BLK_W-1:0]    key_prev;
    logic [AES_BLK_W-1:0]    add_key;
    logic [AES_BLK_W-1:0]    mixed;
    logic [1:0]              kb_sel;
    logic [7:0]              sb_in, sb_out;

    assign round_legal = (round != 4'd0) && (round <= 4'd10);

    // ------------------------------------------------------------------
    // Inverse key step. w1'..w3' are plain XORs of the registered key;
    // w0' needs SubWord(RotWord(w3')), collected byte by byte during SUB.
    // ------------------------------------------------------------------
    assign w0 = key_q[31:0];
    assign w1 = key_q[63:32];
    assign w2 = key_q[95:64];
    assign w3 = key_q[127:96];

    assign w3_prev  = w3 ^ w2;
    assign w2_prev  = w2 ^ w1;
    assign w1_prev  = w1 ^ w0;
    assign rcon_idx = round_q - 4'd1;
    assign w0_prev  = w0 ^ subw_q ^ {24'h000000, RCON[rcon_idx]};
    assign key_prev = {w3_prev, w2_prev, w1_prev, w0_prev};

    assign add_key  = stage_q ^ key_prev;
    assign mixed    = inv_mix_columns(add_key);

    // RotWord moves byte (k+1) mod 4 into byte k, so key byte k looks up
    // byte k+1 of w3'.
    assign kb_sel = cnt_q[1:0] + 2'd1;
    assign sb_in  = w3_prev[8*kb_sel +: 8];

    sbox u_sbox (
        .in_byte  (sb_in),
        .out_byte (sb_out)
    );

    // ------------------------------------------------------------------
    // InvShiftRows + InvSubBytes datapath
    // ------------------------------------------------------------------
`ifdef AES_INV_PARALLEL_EN
    logic [7:0] isb_in  [4];
    logic [7:0] isb_out [4];

    for (genvar j = 0; j < 4; j++) begin : g_isb
        assign isb_in[j] = text_q[8*INV_SR_MAP[{cnt_q, 2'(j)}] +: 8];
        inv_sbox u_inv_sbox (
            .in_byte  (isb_in[j]),
            .out_byte (isb_out[j])
        );
    end
`else
    logic [7:0] isb_in;
    logic [7:0] isb_out;

    assign isb_in = text_q[8*INV_SR_MAP[cnt_q] +: 8];

    inv_sbox u_inv_sbox (
        .in_byte  (isb_in),
        .out_byte (isb_out)
    );
`endif

    // ------------------------------------------------------------------
    // FSM next state and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        text_d   = text_q;
        key_d    = key_q;
        round_d  = round_q;
        stage_d  = stage_q;
        subw_d   = subw_q;
        o_text_d = o_text_q;
        o_key_d  = o_key_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && round_legal) begin
                    text_d  = i_text;
                    key_d   = key;
                    round_d = round;
                    cnt_d   = '0;
                    state_d = SUB;
                end
            end

            SUB: begin
`ifdef AES_INV_PARALLEL_EN
                for (int j = 0; j < 4; j++) begin
                    stage_d[32*cnt_q + 8*j +: 8] = isb_out[j];
                end
                subw_d[8*cnt_q +: 8] = sb_out;
`else
                stage_d[8*cnt_q +: 8] = isb_out;
                if (cnt_q < 4'd4) begin
                    subw_d[8*cnt_q[1:0] +: 8] = sb_out;
                end
`endif
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = FIN;
                end
            end

            FIN: begin
                o_key_d  = key_prev;
                o_text_d = (round_q == 4'd1) ? add_key : mixed;
                done_d   = 1'b1;
                state_d  = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            text_q   <= '0;
            key_q    <= '0;
            round_q  <= '0;
            stage_q  <= '0;
            subw_q   <= '0;
            o_text_q <= '0;
            o_key_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            text_q   <= text_d;
            key_q    <= key_d;
            round_q  <= round_d;
            stage_q  <= stage_d;
            subw_q   <= subw_d;
            o_text_q <= o_text_d;
            o_key_q  <= o_key_d;
            done_q   <= done_d;
        end
    end

    assign o_text    = o_text_q;
    assign o_key     = o_key_q;
    assign done      = done_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_aes_inv_round.sv
// tb_aes_inv_round: directed bench for aes_inv_round using FIPS-197 C.1
// vectors. Strings below are written byte 0 leftmost and are byte-reversed
// onto the ports. A monitor pops the expected queue on every done pulse.
module tb_aes_inv_round;

`ifdef AES_INV_PARALLEL_EN
    localparam int LAT    = 5;
    localparam int RST_AT = 2;
`else
    localparam int LAT    = 17;
    localparam int RST_AT = 8;
`endif

    localparam logic [127:0] C1_IN  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
    localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_OK  = 128'h549932d1f08557681093ed9cbe2c974e;
    localparam logic [127:0] C1_OT  = 128'h54d990a16ba09ab596bbf40ea111702f;
    localparam logic [127:0] C2_IN  = 128'h6353e08c0960e104cd70b751bacad0e7;
    localparam logic [127:0] C2_KEY = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K0     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clock;
    logic         reset;
    logic         start;
    logic [127:0] i_text;
    logic [127:0] key;
    logic [3:0]   round;
    logic [127:0] o_text;
    logic [127:0] o_key;
    logic         busy;
    logic         done;
    logic [1:0]   state_dbg;

    aes_inv_round dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .i_text    (i_text),
        .key       (key),
        .round     (round),
        .o_text    (o_text),
        .o_key     (o_key),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [127:0] exp_text_q [$];
    logic [127:0] exp_key_q  [$];
    logic [0:0]   exp_chk_q  [$];
    int           exp_cyc_q  [$];

    int n_cmp    = 0;
    int n_err    = 0;
    int done_cnt = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    function automatic logic [127:0] brev(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
        return y;
    endfunction

    always @(negedge clock) begin
        if (!reset && done) begin
            logic [127:0] et, ek;
            logic [0:0]   c;
            int           ec;
            done_cnt++;
            if (exp_text_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d required no pending request", cyc);
            end else begin
                et = exp_text_q.pop_front();
                ek = exp_key_q.pop_front();
                c  = exp_chk_q.pop_front();
                ec = exp_cyc_q.pop_front();
                chk("done_cycle", 128'(cyc), 128'(ec));
                chk("busy_in_done_cycle", 128'(busy), 128'(0));
                if (c == 1'b1) begin
                    chk("o_text", o_text, et);
                    chk("o_key", o_key, ek);
                end
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic issue(input logic [127:0] t, input logic [127:0] k, input logic [3:0] r,
                         input logic [127:0] et, input logic [127:0] ek,
                         input bit c, input bit acc);
        i_text = t;
        key    = k;
        round  = r;
        start  = 1'b1;
        if (acc) begin
            exp_text_q.push_back(et);
            exp_key_q.push_back(ek);
            exp_chk_q.push_back(c);
            exp_cyc_q.push_back(cyc + 1 + LAT);
        end
        @(negedge clock);
        start  = 1'b0;
        i_text = {$urandom, $urandom, $urandom, $urandom};
        key    = {$urandom, $urandom, $urandom, $urandom};
        round  = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no done after %0d cycles required done", nm, n);
        end
    endtask

    // ---------------- stimulus ----------------
    logic [127:0] t, k, et, ek;
    bit           c;
    int           d0;

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        i_text = '0;
        key    = '0;
        round  = '0;
        repeat (3) @(negedge clock);
        chk("reset_o_text", o_text, '0);
        chk("reset_o_key", o_key, '0);
        chk("reset_done", 128'(done), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));
        reset = 1'b0;
        @(negedge clock);

        // Case 1: round 10
        issue(brev(C1_IN), brev(C1_KEY), 4'd10, brev(C1_OT), brev(C1_OK), 1'b1, 1'b1);
        chk("c1_busy", 128'(busy), 128'(1));
        wait_done("c1");
        @(negedge clock);
        chk("c1_done_one_cycle", 128'(done), 128'(0));
        chk("c1_o_text_hold", o_text, brev(C1_OT));

        // Case 2: round 1, InvMixColumns bypassed
        issue(brev(C2_IN), brev(C2_KEY), 4'd1, brev(PT), brev(K0), 1'b1, 1'b1);
        wait_done("c2");
        @(negedge clock);

        // Case 3: full chain, each round started in the previous done cycle
        k = brev(C1_KEY);
        t = brev(CT) ^ k;
        for (int r = 10; r >= 1; r--) begin
            c  = 1'b0;
            et = '0;
            ek = '0;
            if (r == 10) begin c = 1'b1; et = brev(C1_OT); ek = brev(C1_OK);  end
            if (r == 2)  begin c = 1'b1; et = brev(C2_IN); ek = brev(C2_KEY); end
            if (r == 1)  begin c = 1'b1; et = brev(PT);    ek = brev(K0);     end
            issue(t, k, 4'(r), et, ek, c, 1'b1);
            chk("chain_busy_after_start", 128'(busy), 128'(1));
            wait_done("chain");
            t = o_text;
            k = o_key;
        end
        chk("chain_plaintext", t, brev(PT));
        @(negedge clock);

        // Case 4: second start mid-round is dropped
        d0 = done_cnt;
        issue(brev(C1_IN), brev(C1_KEY), 4'd10, brev(C1_OT), brev(C1_OK), 1'b1, 1'b1);
        repeat (4) @(negedge clock);
        chk("c4_busy_at_restart", 128'(busy), 128'(1));
        i_text = brev(C2_IN);
        key    = brev(C2_KEY);
        round  = 4'd1;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        wait_done("c4");
        repeat (25) @(negedge clock);
        chk("c4_single_done", 128'(done_cnt - d0), 128'(1));

        // Case 5: reset mid-SUB aborts, then a fresh round completes
        issue(brev(C1_IN), brev(C1_KEY), 4'd10, brev(C1_OT), brev(C1_OK), 1'b1, 1'b1);
        repeat (RST_AT) @(negedge clock);
        reset = 1'b1;
        exp_text_q.delete();
        exp_key_q.delete();
        exp_chk_q.delete();
        exp_cyc_q.delete();
        @(negedge clock);
        chk("c5_busy", 128'(busy), 128'(0));
        chk("c5_done", 128'(done), 128'(0));
        chk("c5_o_text", o_text, '0);
        chk("c5_o_key", o_key, '0);
        reset = 1'b0;
        issue(brev(C2_IN), brev(C2_KEY), 4'd1, brev(PT), brev(K0), 1'b1, 1'b1);
        wait_done("c5");
        @(negedge clock);

        // Case 6: illegal round numbers are ignored
        d0 = done_cnt;
        issue(brev(C1_IN), brev(C1_KEY), 4'd0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("c6_busy_round0", 128'(busy), 128'(0));
            @(negedge clock);
        end
        issue(brev(C1_IN), brev(C1_KEY), 4'd11, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("c6_busy_round11", 128'(busy), 128'(0));
            @(negedge clock);
        end
        repeat (20) @(negedge clock);
        chk("c6_no_done", 128'(done_cnt - d0), 128'(0));

        // Drain
        for (int i = 0; i < 40 && exp_text_q.size() != 0; i++) @(negedge clock);
        chk("scoreboard_drained", 128'(exp_text_q.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
